periph_bus_master: RTL

//   Initiator side of the 8-bit-address / 32-bit-data peripheral register bus
//   (address, write_data, read_data, we, re) that GPIO and other peripherals answer.

---
 rtl/periph_bus_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/periph_bus_master.sv
// Initiator for the 8-bit-address / 32-bit-data peripheral register bus.
// Takes one request at a time and runs it as a read, a write, or an atomic
// read-modify-write (set/clear bits), then returns the result on a response channel.
module periph_bus_master #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned READ_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_write_data,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [DATA_W-1:0] bus_read_data
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic [1:0]        r_op,    w_op_nxt;
  logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;

  logic              r_bus_we,         w_bus_we_nxt;
  logic              r_bus_re,         w_bus_re_nxt;
  logic [ADDR_W-1:0] r_bus_address,    w_bus_address_nxt;
  logic [DATA_W-1:0] r_bus_write_data, w_bus_write_data_nxt;
  logic              r_rsp_valid,      w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata,      w_rsp_rdata_nxt;
  logic              r_busy,           w_busy_nxt;
  logic              r_req_ready,      w_req_ready_nxt;

  logic w_read_done;

  assign w_read_done = (r_cnt == CNT_W'(READ_WAIT));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, latched request fields and next values of every output register
  always_comb begin
    w_state_nxt          = r_state;
    w_op_nxt             = r_op;
    w_addr_nxt           = r_addr;
    w_wdata_nxt          = r_wdata;
    w_rdata_nxt          = r_rdata;
    w_cnt_nxt            = r_cnt;
    w_bus_we_nxt         = 1'b0;
    w_bus_re_nxt         = 1'b0;
    w_bus_address_nxt    = '0;
    w_bus_write_data_nxt = '0;
    w_rsp_valid_nxt      = 1'b0;
    w_rsp_rdata_nxt      = r_rsp_rdata;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_op_nxt    = req_op;
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          w_cnt_nxt   = '0;
          if (req_op == OP_WRITE) begin
            w_state_nxt          = S_WRITE;
            w_bus_we_nxt         = 1'b1;
            w_bus_address_nxt    = req_addr;
            w_bus_write_data_nxt = req_wdata;
          end else begin
            w_state_nxt       = S_READ;
            w_bus_re_nxt      = 1'b1;
            w_bus_address_nxt = req_addr;
          end
        end
      end
      S_READ: begin
        if (w_read_done) begin
          w_rdata_nxt = bus_read_data;
          unique case (r_op)
            OP_SET: begin
              w_state_nxt          = S_WRITE;
              w_bus_we_nxt         = 1'b1;
              w_bus_address_nxt    = r_addr;
              w_bus_write_data_nxt = bus_read_data | r_wdata;
            end
            OP_CLR: begin
              w_state_nxt          = S_WRITE;
              w_bus_we_nxt         = 1'b1;
              w_bus_address_nxt    = r_addr;
              w_bus_write_data_nxt = bus_read_data & ~r_wdata;
            end
            default: begin
              w_state_nxt     = S_RESP;
              w_rsp_valid_nxt = 1'b1;
              w_rsp_rdata_nxt = bus_read_data;
            end
          endcase
        end else begin
          w_cnt_nxt         = r_cnt + CNT_W'(1);
          w_bus_re_nxt      = 1'b1;
          w_bus_address_nxt = r_addr;
        end
      end
      S_WRITE: begin
        // Plain write echoes the written value; RMW returns the pre-modify value
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rdata_nxt = (r_op == OP_WRITE) ? r_bus_write_data : r_rdata;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt     = S_IDLE;
        else           w_rsp_valid_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // Latched request fields, counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op             <= OP_READ;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_rdata          <= '0;
      r_cnt            <= '0;
      r_bus_we         <= 1'b0;
      r_bus_re         <= 1'b0;
      r_bus_address    <= '0;
      r_bus_write_data <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_rdata      <= '0;
      r_busy           <= 1'b0;
      r_req_ready      <= 1'b1;
    end else begin
      r_op             <= w_op_nxt;
      r_addr           <= w_addr_nxt;
      r_wdata          <= w_wdata_nxt;
      r_rdata          <= w_rdata_nxt;
      r_cnt            <= w_cnt_nxt;
      r_bus_we         <= w_bus_we_nxt;
      r_bus_re         <= w_bus_re_nxt;
      r_bus_address    <= w_bus_address_nxt;
      r_bus_write_data <= w_bus_write_data_nxt;
      r_rsp_valid      <= w_rsp_valid_nxt;
      r_rsp_rdata      <= w_rsp_rdata_nxt;
      r_busy           <= w_busy_nxt;
      r_req_ready      <= w_req_ready_nxt;
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign busy           = r_busy;
  assign bus_address    = r_bus_address;
  assign bus_write_data = r_bus_write_data;
  assign bus_we         = r_bus_we;
  assign bus_re         = r_bus_re;

endmodule
